uart_receiver: RTL and testbench

//  Configurable UART receiver with an integrated 16x-oversampling baud tick generator.

---
 rtl/uart_pkg.sv | 63 ++++++
 rtl/uart_baud_tick_gen.sv | 50 +++++
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, baud table and select decoders for the UART receiver.
// The baud divisor is computed at elaboration time from the clock frequency.
package uart_pkg;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;
   typedef enum logic [1:0] {Stop1, Stop15, Stop2} stop_e;
   typedef enum logic [1:0] {ParNone, ParEven, ParOdd} parity_e;

   localparam int unsigned NumBaudSel = 16;

   function automatic int unsigned baud_of(input logic [3:0] sel);
      case (sel)
         4'd0:    return 300;
         4'd1:    return 1200;
         4'd2:    return 2400;
         4'd3:    return 4800;
         4'd4:    return 9600;
         4'd5:    return 19200;
         4'd6:    return 38400;
         4'd7:    return 57600;
         4'd8:    return 115200;
         4'd9:    return 230400;
         4'd10:   return 460800;
         4'd11:   return 921600;
         default: return 115200;
      endcase
   endfunction

   // Rounded clk_freq / (oversamp * baud).
   function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                                input int unsigned oversamp,
                                                input logic [3:0]  sel);
      int unsigned den;
      den = oversamp * baud_of(sel);
      return (clk_freq + den / 2) / den;
   endfunction

   function automatic logic [3:0] data_bits(input logic [2:0] sel);
      case (sel)
         3'd0:    return 4'd5;
         3'd1:    return 4'd6;
         3'd2:    return 4'd7;
         default: return 4'd8;
      endcase
   endfunction

   function automatic stop_e stop_mode(input logic [1:0] sel);
      case (sel)
         2'd0:    return Stop1;
         2'd1:    return Stop15;
         default: return Stop2;
      endcase
   endfunction

   function automatic parity_e parity_mode(input logic [1:0] sel);
      case (sel)
         2'd1:    return ParEven;
         2'd2:    return ParOdd;
         default: return ParNone;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversampling tick generator: one-cycle s_tick every D clocks for the selected baud rate.
// A change of baud_rate_sel restarts the count from zero.
module uart_baud_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned OVERSAMP = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] baud_rate_sel,
   output logic       s_tick
);

   // Sel 0 (300 baud) has the largest divisor, so it sets the counter width.
   localparam int unsigned CntW = $clog2(baud_divisor(CLK_FREQ, OVERSAMP, 4'd0) + 1);

   logic [CntW-1:0] div_tab [NumBaudSel];
   logic [CntW-1:0] div_m1;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      sel_q;
   logic            sel_changed;

   for (genvar g = 0; g < NumBaudSel; g++) begin : g_div
      assign div_tab[g] = CntW'(baud_divisor(CLK_FREQ, OVERSAMP, 4'(g)) - 1);
   end

   assign div_m1      = div_tab[baud_rate_sel];
   assign sel_changed = (baud_rate_sel != sel_q);

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (sel_changed || cnt_q == div_m1) begin
         cnt_d = '0;
      end
   end

   assign s_tick = (cnt_q == div_m1) && !sel_changed;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         sel_q <= baud_rate_sel;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= baud_rate_sel;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// Configurable UART receiver: 5-8 data bits, none/even/odd parity, 1/1.5/2 stop bits,
// sampling mid-bit using 16x oversampling ticks from the integrated baud generator.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned OVERSAMP = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic [3:0] baud_rate_sel,
   input  logic [2:0] dbit_select_i,
   input  logic [1:0] sbit_select_i,
   input  logic [1:0] parity_select_i,
   output logic       s_tick,
   output logic       rx_done_tick,
   output logic [7:0] rx_dout,
   output logic       parity_error,
   output logic       frame_error
);

   rx_state_e  state_q, state_d;
   logic       rx_meta_q, rx_sync_q;
   logic [4:0] s_q, s_d;
   logic [2:0] n_q, n_d;
   logic [7:0] shreg_q, shreg_d;
   logic [3:0] nbits_q, nbits_d;
   stop_e      stop_q, stop_d;
   parity_e    par_q, par_d;
   logic       p_err_q, p_err_d;
   logic       f_err_q, f_err_d;
   logic       done_q, done_d;
   logic [7:0] dout_q, dout_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       finish;

   uart_baud_tick_gen #(
      .CLK_FREQ(CLK_FREQ),
      .OVERSAMP(OVERSAMP)
   ) u_tick_gen (
      .clk          (clk),
      .reset        (reset),
      .baud_rate_sel(baud_rate_sel),
      .s_tick       (s_tick)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      nbits_d = nbits_q;
      stop_d  = stop_q;
      par_d   = par_q;
      p_err_d = p_err_q;
      f_err_d = f_err_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      finish  = 1'b0;
      case (state_q)
         StIdle: begin
            if (!rx_sync_q) begin
               nbits_d = data_bits(dbit_select_i);
               stop_d  = stop_mode(sbit_select_i);
               par_d   = parity_mode(parity_select_i);
               s_d     = '0;
               shreg_d = '0;
               p_err_d = 1'b0;
               f_err_d = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (s_q == 5'd7) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = rx_sync_q ? StIdle : StData;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (s_q == 5'd15) begin
                  s_d     = '0;
                  shreg_d = {rx_sync_q, shreg_q[7:1]};
                  n_d     = n_q + 3'd1;
                  if ({1'b0, n_q} == nbits_q - 4'd1) begin
                     state_d = (par_q == ParNone) ? StStop : StParity;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StParity: begin
            if (s_tick) begin
               if (s_q == 5'd15) begin
                  s_d = '0;
                  // Unused low bits of shreg are zero, so its XOR covers only the data bits.
                  if (rx_sync_q != ((^shreg_q) ^ (par_q == ParOdd))) begin
                     p_err_d = 1'b1;
                  end
                  state_d = StStop;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StStop: begin
            if (s_tick) begin
               s_d = s_q + 5'd1;
               if ((s_q == 5'd15 || s_q == 5'd31) && !rx_sync_q) begin
                  f_err_d = 1'b1;
               end
               finish = (stop_q == Stop1  && s_q == 5'd15) ||
                        (stop_q == Stop15 && s_q == 5'd23) ||
                        (stop_q == Stop2  && s_q == 5'd31);
               if (finish) begin
                  done_d  = 1'b1;
                  dout_d  = shreg_q >> (4'd8 - nbits_q);
                  perr_d  = p_err_d;
                  ferr_d  = f_err_d;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         s_q       <= '0;
         n_q       <= '0;
         shreg_q   <= '0;
         nbits_q   <= 4'd8;
         stop_q    <= Stop1;
         par_q     <= ParNone;
         p_err_q   <= 1'b0;
         f_err_q   <= 1'b0;
         done_q    <= 1'b0;
         dout_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         s_q       <= s_d;
         n_q       <= n_d;
         shreg_q   <= shreg_d;
         nbits_q   <= nbits_d;
         stop_q    <= stop_d;
         par_q     <= par_d;
         p_err_q   <= p_err_d;
         f_err_q   <= f_err_d;
         done_q    <= done_d;
         dout_q    <= dout_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_done_tick = done_q;
   assign rx_dout      = dout_q;
   assign parity_error = perr_q;
   assign frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 100 MHz / 115200 baud; frames are paced on the DUT's
// own s_tick, 16 ticks per bit, and results are checked against hand-computed values.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [3:0] baud_rate_sel = 4'd8;
   logic [2:0] dbit_select_i = 3'd3;
   logic [1:0] sbit_select_i = 2'd0;
   logic [1:0] parity_select_i = 2'd0;
   logic       s_tick;
   logic       rx_done_tick;
   logic [7:0] rx_dout;
   logic       parity_error;
   logic       frame_error;

   int n_cmp = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int d0;
   int period;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLK_FREQ(100_000_000),
      .OVERSAMP(16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx             (rx),
      .baud_rate_sel  (baud_rate_sel),
      .dbit_select_i  (dbit_select_i),
      .sbit_select_i  (sbit_select_i),
      .parity_select_i(parity_select_i),
      .s_tick         (s_tick),
      .rx_done_tick   (rx_done_tick),
      .rx_dout        (rx_dout),
      .parity_error   (parity_error),
      .frame_error    (frame_error)
   );

   always @(negedge clk) begin
      if (rx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (s_tick !== 1'b1 && guard < 2000);
         if (guard >= 2000) begin
            n_cmp++;
            n_fail++;
            $error("FAIL tick_timeout: observed no s_tick in %0d cycles expected one", guard);
            return;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                             input logic pbit, input logic stop_val, input int stop_ticks);
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < nbits; i++) begin
         rx = data[i];
         wait_ticks(16);
      end
      if (has_par) begin
         rx = pbit;
         wait_ticks(16);
      end
      rx = stop_val;
      wait_ticks(stop_ticks);
      rx = 1'b1;
      wait_ticks(4);
   endtask

   task automatic check_frame(input string tag, input int exp_done, input logic [7:0] exp_dout,
                              input logic exp_perr, input logic exp_ferr);
      check({tag, "_done"}, done_cnt - d0, exp_done);
      check({tag, "_dout"}, rx_dout, exp_dout);
      check({tag, "_perr"}, parity_error, exp_perr);
      check({tag, "_ferr"}, frame_error, exp_ferr);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_s_tick", s_tick, 1'b0);
      check("rst_done", rx_done_tick, 1'b0);
      check("rst_dout", rx_dout, 8'h00);
      check("rst_perr", parity_error, 1'b0);
      check("rst_ferr", frame_error, 1'b0);

      // 8N1, 0xAC
      d0 = done_cnt;
      send_frame(8'hAC, 8, 1'b0, 1'b0, 1'b1, 16);
      check_frame("8n1", 1, 8'hAC, 1'b0, 1'b0);

      // 7 bits, even parity, 2 stop, 0x15 has three ones -> parity bit 1
      dbit_select_i = 3'd2; parity_select_i = 2'd1; sbit_select_i = 2'd2;
      d0 = done_cnt;
      send_frame(8'h15, 7, 1'b1, 1'b1, 1'b1, 32);
      check_frame("7e2", 1, 8'h15, 1'b0, 1'b0);
      d0 = done_cnt;
      send_frame(8'h15, 7, 1'b1, 1'b0, 1'b1, 32);
      check_frame("7e2_flip", 1, 8'h15, 1'b1, 1'b0);

      // 6 bits, odd parity, 1 stop, 0x1E has four ones -> parity bit 1
      dbit_select_i = 3'd1; parity_select_i = 2'd2; sbit_select_i = 2'd0;
      d0 = done_cnt;
      send_frame(8'h1E, 6, 1'b1, 1'b1, 1'b1, 16);
      check_frame("6o1", 1, 8'h1E, 1'b0, 1'b0);

      // 5N1, 0x1B
      dbit_select_i = 3'd0; parity_select_i = 2'd0;
      d0 = done_cnt;
      send_frame(8'h1B, 5, 1'b0, 1'b0, 1'b1, 16);
      check_frame("5n1", 1, 8'h1B, 1'b0, 1'b0);

      // 8N1 with low stop bit; released before the re-detected start passes its mid check
      dbit_select_i = 3'd3;
      d0 = done_cnt;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 12);
      check_frame("stop_low", 1, 8'h5A, 1'b0, 1'b1);

      // 4-tick glitch: no frame, outputs hold
      d0 = done_cnt;
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(16);
      check_frame("glitch", 0, 8'h5A, 1'b0, 1'b1);

      // s_tick period at 115200 baud, then 230400 after a select change
      wait_ticks(1);
      period = 0;
      do begin @(negedge clk); period++; end while (s_tick !== 1'b1 && period < 1000);
      check("tick_period_115200", period, 54);
      baud_rate_sel = 4'd9;
      wait_ticks(1);
      period = 0;
      do begin @(negedge clk); period++; end while (s_tick !== 1'b1 && period < 1000);
      check("tick_period_230400", period, 27);
      baud_rate_sel = 4'd8;
      wait_ticks(1);

      // Reset mid-frame
      d0 = done_cnt;
      rx = 1'b0;
      wait_ticks(40);
      reset = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_done_now", rx_done_tick, 1'b0);
      wait_ticks(40);
      check_frame("midrst", 0, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
